// File: rtl/uart_packet_reader.sv
// uart_packet_reader: drains a UART RX FIFO, parses SYNC/LEN/payload/CHK frames and
// streams each payload to a valid/ready consumer only once its XOR checksum verifies.
module uart_packet_reader #(
    parameter int         MAX_LEN   = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty,
    input  logic [7:0] data_in,
    output logic       read,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_timeout,
    output logic [7:0] pkt_count,
    output logic       busy
);
    localparam int          IW        = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 2);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, DELIVER} state_t;

    state_t      state_q, state_d;
    logic        read_q, read_d, pend_q;
    logic [7:0]  len_q, len_d, idx_q, idx_d, csum_q, csum_d, cnt_q, cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic        err_chk_q, err_chk_d, err_len_q, err_len_d, err_tmo_q, err_tmo_d;
    logic [7:0]  buf_q [MAX_LEN];
    logic        counting, tmo_hit;

    assign counting    = state_q == LEN || state_q == PAYLOAD || state_q == CHK;
    // Fires on the edge where the counter would become TIMEOUT-1; a byte strobe wins.
    assign tmo_hit     = counting && !pend_q && tmo_q == TMO_LAST;
    assign read        = read_q;
    assign out_valid   = state_q == DELIVER;
    assign out_last    = out_valid && idx_q == len_q - 8'd1;
    assign out_data    = out_valid ? buf_q[idx_q[IW-1:0]] : 8'd0;
    assign err_chk     = err_chk_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_tmo_q;
    assign pkt_count   = cnt_q;
    assign busy        = state_q != HUNT;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        cnt_d     = cnt_q;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        err_tmo_d = tmo_hit;
        tmo_d     = (counting && !pend_q) ? tmo_q + 16'd1 : 16'd0;
        case (state_q)
            HUNT: if (pend_q && data_in == SYNC_BYTE) state_d = LEN;
            LEN: if (pend_q) begin
                if (data_in != 8'd0 && data_in <= MAX_LEN_B) begin
                    len_d   = data_in;
                    csum_d  = data_in;
                    idx_d   = 8'd0;
                    state_d = PAYLOAD;
                end else begin
                    err_len_d = 1'b1;
                    state_d   = HUNT;
                end
            end
            PAYLOAD: if (pend_q) begin
                csum_d  = csum_q ^ data_in;
                idx_d   = idx_q + 8'd1;
                state_d = idx_d == len_q ? CHK : PAYLOAD;
            end
            CHK: if (pend_q) begin
                if (data_in == csum_q) begin
                    idx_d   = 8'd0;
                    state_d = DELIVER;
                end else begin
                    err_chk_d = 1'b1;
                    state_d   = HUNT;
                end
            end
            DELIVER: if (out_ready) begin
                idx_d = idx_q + 8'd1;
                if (out_last) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
        if (tmo_hit) state_d = HUNT;
        // Looking at the next state keeps read low through all of DELIVER.
        read_d = state_d != DELIVER && !empty && !read_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= HUNT;
            read_q    <= 1'b0;
            pend_q    <= 1'b0;
            len_q     <= 8'd0;
            idx_q     <= 8'd0;
            csum_q    <= 8'd0;
            cnt_q     <= 8'd0;
            tmo_q     <= 16'd0;
            err_chk_q <= 1'b0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            read_q    <= read_d;
            pend_q    <= read_q;
            len_q     <= len_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            err_chk_q <= err_chk_d;
            err_len_q <= err_len_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == PAYLOAD && pend_q) buf_q[idx_q[IW-1:0]] <= data_in;
    end
endmodule

// File: tb/tb_uart_packet_reader.sv
// tb_uart_packet_reader: drives a queue-backed RX FIFO and checks delivered payloads,
// error pulses and timing against a frame-parsing reference model.
module tb_uart_packet_reader;
    localparam int         TO   = 300;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0, rst = 1'b0, empty = 1'b1, out_ready = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       read, out_valid, out_last, err_chk, err_len, err_timeout, busy;
    logic [7:0] out_data, pkt_count;

    int tests = 0, fails = 0;
    int tick_n = 0, last_read_tick = -10, first_valid_tick = -1, tmo_tick = -1;
    int rmode = 0, n_chk, n_len, n_tmo, e_len, e_chk, e_pk, pk0;
    bit viol_spacing, viol_dread, viol_eread, viol_stable, viol_excl, hold, hold_l;
    logic [7:0] hold_d;
    byte unsigned fifo[$], sent[$], got[$], exp_d[$];
    bit got_last[$], exp_l[$];
    int pop_ticks[$];

    uart_packet_reader #(.MAX_LEN(16), .SYNC_BYTE(SYNC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .empty(empty), .data_in(data_in), .read(read),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .err_chk(err_chk), .err_len(err_len), .err_timeout(err_timeout),
        .pkt_count(pkt_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the byte stream frame by frame using the framing rules directly.
    function automatic void model(input byte unsigned s[$]);
        int i, l;
        byte unsigned x;
        exp_d.delete(); exp_l.delete();
        e_len = 0; e_chk = 0; e_pk = 0; i = 0;
        while (i < s.size()) begin
            if (s[i] != SYNC) i++;
            else if (i + 1 >= s.size()) break;
            else begin
                l = int'(s[i+1]);
                if (l == 0 || l > 16) begin
                    e_len++;
                    i += 2;
                end else if (i + 2 + l >= s.size()) break;
                else begin
                    x = s[i+1];
                    for (int k = 0; k < l; k++) x ^= s[i+2+k];
                    if (x == s[i+2+l]) begin
                        for (int k = 0; k < l; k++) begin
                            exp_d.push_back(s[i+2+k]);
                            exp_l.push_back(k == l - 1);
                        end
                        e_pk++;
                    end else e_chk++;
                    i += 3 + l;
                end
            end
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        tick_n++;
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = $urandom_range(0, 3) != 0;
            2: out_ready = tick_n % 3 == 0;
            default: out_ready = 1'b0;
        endcase
        if (hold && (out_valid !== 1'b1 || out_data !== hold_d || out_last !== hold_l)) viol_stable = 1;
        hold = out_valid && !out_ready;
        hold_d = out_data;
        hold_l = out_last;
        if (out_valid && out_ready) begin
            got.push_back(out_data);
            got_last.push_back(out_last);
        end
        if (out_valid && first_valid_tick < 0) first_valid_tick = tick_n;
        if (err_timeout && tmo_tick < 0) tmo_tick = tick_n;
        if (read) begin
            if (out_valid) viol_dread = 1;
            if (tick_n - last_read_tick < 2) viol_spacing = 1;
            last_read_tick = tick_n;
            pop_ticks.push_back(tick_n);
            if (fifo.size() == 0) viol_eread = 1;
            else data_in = fifo.pop_front();
        end
        if (int'(err_chk) + int'(err_len) + int'(err_timeout) > 1) viol_excl = 1;
        n_chk += int'(err_chk);
        n_len += int'(err_len);
        n_tmo += int'(err_timeout);
        empty = fifo.size() == 0;
    endtask

    task automatic push(input byte unsigned b);
        fifo.push_back(b);
        sent.push_back(b);
        empty = 1'b0;
    endtask

    task automatic push_frame(input int len, input bit bad);
        byte unsigned x, b;
        x = 8'(len);
        push(SYNC);
        push(8'(len));
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            x ^= b;
            push(b);
        end
        push(bad ? x ^ 8'($urandom_range(1, 255)) : x);
    endtask

    task automatic begin_scn();
        sent.delete(); got.delete(); got_last.delete(); pop_ticks.delete();
        n_chk = 0; n_len = 0; n_tmo = 0;
        viol_spacing = 0; viol_dread = 0; viol_eread = 0; viol_stable = 0; viol_excl = 0;
        hold = 0; first_valid_tick = -1; tmo_tick = -1;
        pk0 = int'(pkt_count);
    endtask

    task automatic drain(input string tag, input int max);
        int idle;
        idle = 0;
        for (int i = 0; i < max && idle < 3; i++) begin
            tick();
            idle = (fifo.size() == 0 && !busy && !read) ? idle + 1 : 0;
        end
        check({tag, "_idle"}, idle, 3);
    endtask

    task automatic finish_scn(input string tag);
        model(sent);
        check({tag, "_nbytes"}, got.size(), exp_d.size());
        for (int i = 0; i < got.size() && i < exp_d.size(); i++) begin
            check({tag, "_data"}, got[i], exp_d[i]);
            check({tag, "_last"}, got_last[i], exp_l[i]);
        end
        check({tag, "_err_len"}, n_len, e_len);
        check({tag, "_err_chk"}, n_chk, e_chk);
        check({tag, "_err_tmo"}, n_tmo, 0);
        check({tag, "_pkt_count"}, pkt_count, (pk0 + e_pk) % 256);
        check({tag, "_protocol"}, {viol_spacing, viol_dread, viol_eread, viol_stable, viol_excl}, 0);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        hold = 0;
        #1 check(tag, {read, out_valid, out_last, out_data, err_chk, err_len, err_timeout, pkt_count, busy}, 0);
        fifo.delete();
        empty = 1'b1;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int push_tick, t10;
        #1 check("reset_state", {read, out_valid, out_last, out_data, err_chk, err_len, err_timeout, pkt_count, busy}, 0);
        tick();
        rst = 1'b1;
        repeat (2) tick();

        // Basic 3-byte packet with latency checks.
        begin_scn(); rmode = 0; push_tick = tick_n;
        push(SYNC); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h03);
        drain("t1", 200);
        finish_scn("t1");
        check("t1_read_lat", pop_ticks.size() > 0 ? pop_ticks[0] : -1, push_tick + 1);
        check("t1_valid_lat", first_valid_tick, pop_ticks.size() > 5 ? pop_ticks[5] + 2 : -100);

        // Bad checksum then a valid one-byte frame.
        begin_scn();
        push(SYNC); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h00);
        push(SYNC); push(8'h01); push(8'h7E); push(8'h7F);
        drain("t2", 200);
        finish_scn("t2");

        // Garbage and illegal lengths.
        begin_scn();
        push(8'h00); push(8'hFF); push(SYNC); push(8'h00); push(SYNC); push(8'h11);
        drain("t3", 200);
        finish_scn("t3");

        // Inter-byte timeout, then recovery.
        begin_scn();
        push(SYNC); push(8'h02); push(8'h10);
        for (int i = 0; i < 20 && pop_ticks.size() < 3; i++) tick();
        t10 = pop_ticks.size() >= 3 ? pop_ticks[2] : -1000;
        for (int i = 0; i < TO + 20 && tmo_tick < 0; i++) tick();
        check("t4_tmo_lat", tmo_tick - t10, TO + 1);
        tick();
        check("t4_tmo_cnt", n_tmo, 1);
        check("t4_busy", busy, 0);
        begin_scn();
        push(SYNC); push(8'h01); push(8'h55); push(8'h54);
        drain("t4b", 200);
        finish_scn("t4b");

        // Backpressure with a queued follow-on frame.
        begin_scn(); rmode = 2;
        push(SYNC); push(8'h04); push(8'hDE); push(8'hAD); push(8'hBE); push(8'hEF); push(8'h26);
        push(SYNC); push(8'h01); push(8'h33); push(8'h32);
        drain("t5", 400);
        finish_scn("t5");

        // Randomized frame mix with random consumer stalls.
        begin_scn(); rmode = 1;
        for (int f = 0; f < 40; f++) begin
            int kind;
            byte unsigned b;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    b = 8'($urandom);
                    push(b == SYNC ? 8'h00 : b);
                end
            end else if (kind == 1) begin
                push(SYNC);
                push($urandom_range(0, 1) != 0 ? 8'h00 : 8'($urandom_range(17, 255)));
            end else push_frame($urandom_range(1, 16), kind == 2);
        end
        drain("rand", 20000);
        finish_scn("rand");

        // Reset mid-payload.
        begin_scn(); rmode = 0;
        push(SYNC); push(8'h08); repeat (3) push(8'($urandom));
        repeat (20) tick();
        check("t6a_busy", busy, 1);
        async_reset("t6a_rst");

        // Reset mid-delivery, then a fresh frame.
        begin_scn(); rmode = 3;
        push_frame(4, 1'b0);
        for (int i = 0; i < 40 && !out_valid; i++) tick();
        check("t6b_valid", out_valid, 1);
        async_reset("t6b_rst");
        rmode = 0;
        begin_scn();
        push(SYNC); push(8'h02); push(8'h12); push(8'h34); push(8'h24);
        drain("t6c", 200);
        finish_scn("t6c");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
